// File: rtl/traffic_light_ctrl_if.sv
// Request inputs and lamp/display drives of the traffic light controller.
// The controller itself attaches through the slave modport.
interface traffic_light_ctrl_if;
   logic       iPED;
   logic       iMAINT;
   logic       oRED;
   logic       oYEL;
   logic       oGRN;
   logic [3:0] oDIG;
   logic       oWALK;
   logic       oTICK;

   modport master (
      output iPED, iMAINT,
      input  oRED, oYEL, oGRN, oDIG, oWALK, oTICK
   );

   modport slave (
      input  iPED, iMAINT,
      output oRED, oYEL, oGRN, oDIG, oWALK, oTICK
   );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Traffic light controller: RED -> GREEN -> YELLOW cycle with a BCD countdown
// digit, pedestrian shortening of GREEN and a maintenance yellow-flash mode.
// All outputs are registered; a prescaler produces one tick every TICK_DIV cycles.
module traffic_light_ctrl #(
   parameter int TICK_DIV = 50_000_000,
   parameter int GREEN_S  = 7,
   parameter int YELLOW_S = 2,
   parameter int RED_S    = 9,
   parameter int PED_MIN  = 2
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   traffic_light_ctrl_if.slave  bus
);

   localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
   localparam logic [3:0]    CNT_RED    = 4'(RED_S);
   localparam logic [3:0]    CNT_GREEN  = 4'(GREEN_S);
   localparam logic [3:0]    CNT_YELLOW = 4'(YELLOW_S);
   localparam logic [3:0]    CNT_PED    = 4'(PED_MIN);
   localparam logic [3:0]    DIG_BLANK  = 4'hF;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2,
      FLASH  = 2'd3
   } state_t;

   state_t        state;
   state_t        stateNext;
   logic [3:0]    cnt;
   logic [3:0]    cntNext;
   logic [PW-1:0] presc;
   logic          tick;
   logic          pedReq;
   logic          pedNext;
   logic          pedSeen;
   logic          flashYelNext;
   logic          prescClr;
   logic          redR;
   logic          yelR;
   logic          grnR;
   logic          walkR;
   logic [3:0]    digR;

   assign bus.oRED  = redR;
   assign bus.oYEL  = yelR;
   assign bus.oGRN  = grnR;
   assign bus.oWALK = walkR;
   assign bus.oDIG  = digR;
   assign bus.oTICK = tick;

   // Next phase, countdown value and pedestrian latch; maintenance overrides everything.
   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      pedNext      = pedReq;
      flashYelNext = yelR;
      prescClr     = 1'b0;
      pedSeen      = pedReq | bus.iPED;
      if (bus.iMAINT) begin
         stateNext = FLASH;
         pedNext   = 1'b0;
         if (state != FLASH) begin
            flashYelNext = 1'b1;
         end else if (tick) begin
            flashYelNext = ~yelR;
         end else begin
            flashYelNext = yelR;
         end
      end else begin
         case (state)
            RED: begin
               pedNext = pedSeen;
               if (tick) begin
                  if (cnt > 4'd1) begin
                     cntNext = cnt - 4'd1;
                  end else begin
                     stateNext = GREEN;
                     cntNext   = CNT_GREEN;
                  end
               end else begin
                  cntNext = cnt;
               end
            end
            GREEN: begin
               pedNext = pedSeen;
               // A pending pedestrian cut wins over a coincident tick.
               if (pedSeen && (cnt > CNT_PED)) begin
                  cntNext = CNT_PED;
               end else if (tick) begin
                  if (cnt > 4'd1) begin
                     cntNext = cnt - 4'd1;
                  end else begin
                     stateNext = YELLOW;
                     cntNext   = CNT_YELLOW;
                  end
               end else begin
                  cntNext = cnt;
               end
            end
            YELLOW: begin
               pedNext = pedSeen;
               if (tick) begin
                  if (cnt > 4'd1) begin
                     cntNext = cnt - 4'd1;
                  end else begin
                     stateNext = RED;
                     cntNext   = CNT_RED;
                     pedNext   = 1'b0;
                  end
               end else begin
                  cntNext = cnt;
               end
            end
            FLASH: begin
               // Leaving maintenance restarts a full RED phase on a fresh tick boundary.
               stateNext = RED;
               cntNext   = CNT_RED;
               pedNext   = 1'b0;
               prescClr  = 1'b1;
            end
            default: begin
               stateNext = RED;
               cntNext   = CNT_RED;
               pedNext   = 1'b0;
               prescClr  = 1'b1;
            end
         endcase
      end
   end

   // Prescaler with registered tick strobe, high while the count sits at TICK_DIV-1.
   always_ff @(posedge iCLK) begin
      if (iRST || prescClr) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc >= PRESC_LAST) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= presc + PW'(1);
         tick  <= (presc == PRESC_PRE);
      end
   end

   // Phase register plus registered lamp, walk and digit drives derived from the next phase.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state  <= RED;
         cnt    <= CNT_RED;
         pedReq <= 1'b0;
         redR   <= 1'b1;
         yelR   <= 1'b0;
         grnR   <= 1'b0;
         walkR  <= 1'b1;
         digR   <= CNT_RED;
      end else begin
         state  <= stateNext;
         cnt    <= cntNext;
         pedReq <= pedNext;
         redR   <= (stateNext == RED);
         grnR   <= (stateNext == GREEN);
         yelR   <= (stateNext == FLASH) ? flashYelNext : (stateNext == YELLOW);
         walkR  <= (stateNext == RED);
         digR   <= (stateNext == FLASH) ? DIG_BLANK : cntNext;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: reset/free-run vector table, hand-written
// pedestrian/maintenance/reset sequences, then random stimulus against a
// cycle-count based reference model.
module tb_traffic_light_ctrl;
   localparam int TD = 4;
   localparam int GS = 5;
   localparam int YS = 2;
   localparam int RS = 4;
   localparam int PM = 2;

   logic iCLK = 1'b0;
   logic iRST;

   traffic_light_ctrl_if tlBus();

   traffic_light_ctrl #(
      .TICK_DIV(TD), .GREEN_S(GS), .YELLOW_S(YS), .RED_S(RS), .PED_MIN(PM)
   ) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (tlBus)
   );

   always #5 iCLK = ~iCLK;

   int tests = 0;
   int fails = 0;

   // Reference model: phase 0=RED 1=GREEN 2=YELLOW 3=FLASH, digit, pedestrian
   // request, flash lamp, and cycles elapsed since the tick grid was last restarted.
   int mPhase = 0;
   int mDig   = RS;
   int mAge   = 0;
   bit mPed   = 1'b0;
   bit mYel   = 1'b0;
   int dur [3];

   typedef struct {
      bit         r;
      bit         p;
      bit         m;
      logic [8:0] exp;
   } vec_t;
   vec_t tbl [18];

   function automatic logic [8:0] mk(input bit red, input bit yel, input bit grn,
                                     input int dig, input bit walk, input bit tk);
      return {red, yel, grn, 4'(dig), walk, tk};
   endfunction

   function automatic logic [8:0] outVec();
      return {tlBus.oRED, tlBus.oYEL, tlBus.oGRN, tlBus.oDIG, tlBus.oWALK, tlBus.oTICK};
   endfunction

   function automatic logic [8:0] modelVec();
      logic [3:0] d;
      bit         y;
      d = (mPhase == 3) ? 4'hF : 4'(mDig);
      y = (mPhase == 3) ? mYel : (mPhase == 2);
      return {mPhase == 0, y, mPhase == 1, d, mPhase == 0, (mAge % TD) == TD - 1};
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic modelStep(input bit r, input bit p, input bit m);
      bit tk;
      bit pedNow;
      int old;
      tk = (mAge % TD) == TD - 1;
      if (r) begin
         mPhase = 0; mDig = RS; mPed = 1'b0; mAge = 0;
      end else if (m) begin
         if (mPhase != 3) mYel = 1'b1;
         else if (tk) mYel = !mYel;
         mPhase = 3; mPed = 1'b0; mAge++;
      end else if (mPhase == 3) begin
         mPhase = 0; mDig = RS; mPed = 1'b0; mAge = 0;
      end else begin
         old    = mPhase;
         pedNow = mPed | p;
         if (mPhase == 1 && pedNow && mDig > PM) begin
            mDig = PM;
         end else if (tk) begin
            if (mDig > 1) mDig--;
            else begin
               mPhase = (mPhase + 1) % 3;
               mDig   = dur[mPhase];
            end
         end
         mPed = (mPhase == 0 && old != 0) ? 1'b0 : pedNow;
         mAge++;
      end
   endtask

   task automatic step(input bit r, input bit p, input bit m);
      iRST         = r;
      tlBus.iPED   = p;
      tlBus.iMAINT = m;
      @(posedge iCLK);
      modelStep(r, p, m);
      #1;
      chk("model", outVec(), modelVec());
   endtask

   function automatic bit at(input int kind, input int dig);
      case (kind)
         0:       return tlBus.oGRN && (tlBus.oDIG == 4'(dig));
         1:       return tlBus.oYEL;
         2:       return tlBus.oRED;
         3:       return tlBus.oGRN && (tlBus.oDIG == 4'(dig)) && tlBus.oTICK;
         4:       return tlBus.oGRN;
         default: return 1'b1;
      endcase
   endfunction

   task automatic runUntil(input int kind, input int dig, input string name);
      int n;
      n = 0;
      while (!at(kind, dig) && n < 120) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (!at(kind, dig)) begin
         tests++;
         fails++;
         $display("FAIL timeout %s: condition not reached, required within 120 cycles", name);
      end
   endtask

   initial begin
      int nt;
      int n;
      int t1;
      int t2;
      bit prevY;
      bit maint;
      bit r;
      bit p;

      iRST         = 1'b1;
      tlBus.iPED   = 1'b0;
      tlBus.iMAINT = 1'b0;
      dur[0] = RS;
      dur[1] = GS;
      dur[2] = YS;

      // Reset beats ped/maint, then free-run RED 4,3,2,1 with a tick every 4th cycle,
      // GREEN entry, and a pedestrian cut at digit 5.
      tbl[0]  = '{1'b1, 1'b1, 1'b1, mk(1, 0, 0, 4, 1, 0)};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 4, 1, 0)};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 4, 1, 0)};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 4, 1, 1)};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 3, 1, 0)};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 3, 1, 0)};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 3, 1, 0)};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 3, 1, 1)};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 2, 1, 0)};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 2, 1, 0)};
      tbl[10] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 2, 1, 0)};
      tbl[11] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 2, 1, 1)};
      tbl[12] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
      tbl[13] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
      tbl[14] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
      tbl[15] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 1)};
      tbl[16] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 1, 5, 0, 0)};
      tbl[17] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 2, 0, 0)};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, tbl[i].p, tbl[i].m);
         chk($sformatf("vec%0d", i), outVec(), tbl[i].exp);
      end

      // Pedestrian pulse at GREEN 5: digit 2 next clock, YELLOW after two more ticks.
      step(1'b1, 1'b0, 1'b0);
      runUntil(0, 5, "green5");
      step(1'b0, 1'b1, 1'b0);
      chk("cut at 5", {5'd0, tlBus.oDIG}, 9'd2);
      nt = 0;
      n  = 0;
      while (!tlBus.oYEL && n < 40) begin
         if (tlBus.oTICK) nt++;
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk("ticks to yellow", 9'(nt), 9'd2);

      // Pedestrian pulse at GREEN 2 changes nothing.
      runUntil(0, 2, "green2");
      step(1'b0, 1'b1, 1'b0);
      chk("no cut at 2", {5'd0, tlBus.oDIG}, 9'd2);

      // Request during RED shortens the next GREEN after one cycle at 5, then clears.
      runUntil(2, 0, "red");
      step(1'b0, 1'b1, 1'b0);
      runUntil(4, 0, "green after red ped");
      chk("green entry digit", {5'd0, tlBus.oDIG}, 9'd5);
      step(1'b0, 1'b0, 1'b0);
      chk("latched cut", {5'd0, tlBus.oDIG}, 9'd2);
      runUntil(2, 0, "red again");
      runUntil(4, 0, "next green");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         chk("request cleared", {5'd0, tlBus.oDIG}, 9'd5);
      end

      // Pedestrian coincident with a tick at GREEN 4: cut wins, digit 2.
      runUntil(3, 4, "green4 tick");
      step(1'b0, 1'b1, 1'b0);
      chk("cut beats tick", {5'd0, tlBus.oDIG}, 9'd2);

      // Maintenance mid-GREEN, yellow flashing every 4 cycles, then release to RED.
      runUntil(2, 0, "red before maint");
      runUntil(0, 3, "green3");
      step(1'b0, 1'b0, 1'b1);
      chk("flash entry", {1'b0, tlBus.oRED, tlBus.oYEL, tlBus.oGRN, tlBus.oDIG, tlBus.oWALK},
          {1'b0, 8'b0_1_0_1111_0});
      t1    = -1;
      t2    = -1;
      prevY = tlBus.oYEL;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b0, 1'b1);
         if (tlBus.oYEL != prevY) begin
            if (t1 < 0) t1 = i;
            else if (t2 < 0) t2 = i;
         end
         prevY = tlBus.oYEL;
      end
      chk("flash toggle period", 9'(t2 - t1), 9'd4);
      step(1'b0, 1'b0, 1'b0);
      chk("flash exit", outVec(), mk(1, 0, 0, 4, 1, 0));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("first tick after flash", {8'd0, tlBus.oTICK}, 9'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("digit after flash tick", {5'd0, tlBus.oDIG}, 9'd3);

      // Reset mid-YELLOW aborts the phase; next tick 4 cycles after deassertion.
      runUntil(1, 0, "yellow");
      step(1'b1, 1'b0, 1'b0);
      chk("reset mid-yellow", outVec(), mk(1, 0, 0, 4, 1, 0));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("no early tick", {8'd0, tlBus.oTICK}, 9'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("tick after reset", {8'd0, tlBus.oTICK}, 9'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("digit after reset tick", {5'd0, tlBus.oDIG}, 9'd3);

      // Random pedestrian, maintenance and reset traffic against the model.
      maint = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 59) == 0) maint = !maint;
         p = ($urandom_range(0, 9) == 0);
         step(r, p, maint);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
